stack_frame_ctrl: RTL and testbench
===================================

# stack_frame_ctrl

Parametrised stack-frame sequencer between the main controller and the stack memory. One request moves a whole frame of FIELDS words: push stores the words in ascending field order, and pop restores them in descending order (LIFO). It drives the stack push/pop strobes, the push-source mux select and one-hot register load enables. It also tracks stack occupancy, with optional overflow/underflow protection.

## Interface
- FIELDS, 3: words per frame; must be ≥ 1
- DEPTH, 64: stack capacity in words; must be ≥ FIELDS
- SEL_W, derived: max(1, clog2(FIELDS))
- SP_W, derived: clog2(DEPTH+1)
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  synchronous reset, active-high
- push_req  in  1  push-frame request, sampled only in IDLE
- pop_req  in  1  pop-frame request, sampled only in IDLE
- ready  out  1  block is idle and accepts a request
- done  out  1  one-cycle pulse when a frame operation (or its rejection) completes
- err  out  1  one-cycle pulse, concurrent with done, when a request was rejected
- push  out  1  stack push strobe
- pop  out  1  stack pop strobe
- push_src  out  SEL_W  push-source mux select (field index)
- en_field  out  FIELDS  one-hot load enable for destination registers on pop
- sp  out  SP_W  occupancy in words
- full  out  1  sp == DEPTH
- empty  out  1  sp == 0

## Operation
- States are IDLE, PUSH, POP and DONE, plus a field index idx (SEL_W bits).
- IDLE:
  - ready=1; all other strobes 0.
  - pop_req has priority: pop_req=1 → POP with idx=FIELDS-1.
  - Otherwise push_req=1 → PUSH with idx=0.
  - Otherwise stay in IDLE.
- PUSH:
  - push=1, push_src=idx, sp increments by 1 per cycle.
  - When idx==FIELDS-1 → DONE; otherwise idx+1.
- POP:
  - pop=1, en_field[idx]=1, sp decrements by 1 per cycle.
  - When idx==0 → DONE; otherwise idx-1.
- DONE: done=1, ready=0 → IDLE.
- Outputs are Moore (decoded from state/idx only); en_field is all-zero outside POP.
- Requests arriving outside IDLE are ignored, not queued. The requester must hold its request until ready is high.
- Simultaneous push_req and pop_req: pop executes and push is dropped.
- full/empty are combinational from sp.

## Timing
- Request sampled on edge k in IDLE:
  - Strobes are active in cycles k+1 … k+FIELDS.
  - done is high in cycle k+FIELDS+1.
  - ready returns in cycle k+FIELDS+2.
- Back-to-back frames: minimum request spacing is FIELDS+2 cycles.
- Reset, including mid-frame: the edge with rst=1 forces IDLE, idx=0 and sp=0.
  - Following cycle: ready=1; done, err, push, pop, push_src, en_field and sp all 0; empty=1, full=0.
  - Partially transferred frames are abandoned, with no done pulse.
- State before the first reset is undefined; the bench must reset first.

## Configuration
- STACK_FRAME_GUARD_EN defined:
  - In IDLE, a push_req with sp > DEPTH-FIELDS is rejected.
  - In IDLE, a pop_req with sp < FIELDS is rejected.
  - Rejection goes IDLE → DONE directly with done=1 and err=1. No push/pop strobes are issued and sp is unchanged.
  - Priority between pop and push is unchanged: a rejected pop does not fall through to push.
- STACK_FRAME_GUARD_EN undefined:
  - No checks are made; err is tied 0.
  - sp wraps modulo 2^SP_W; full/empty remain informational only.

## Structure
- Package stack_ctrl_pkg holds:
  - the state enum (IDLE, PUSH, POP, DONE);
  - a clog2 constant function, used to derive SEL_W and SP_W.
- Sub-module stack_occupancy:
  - up/down counter, SP_W wide, with inc/dec inputs, synchronous rst, and sp/full/empty outputs;
  - inc and dec are never asserted together.
- Top level keeps the FSM, idx counter and output decode.

## Test plan
(FIELDS=3, DEPTH=8, guard enabled unless noted)
- Reset, then push_req for 1 cycle:
  - push high in cycles 1–3 with push_src 0,1,2;
  - done in cycle 4, ready in cycle 5; sp=3.
- Pop after that push:
  - pop high 3 cycles with en_field 100, 010, 001; done once; sp=0, empty=1.
- push_req and pop_req together with sp=6: pop executes (sp=3) and push is dropped.
- Two pushes bring sp to 6; a third push_req is rejected:
  - done=1 and err=1 one cycle after the request; no push strobe; sp stays 6.
  - pop_req at sp=0 behaves the same: err=1 and sp stays 0.
- rst asserted during the second PUSH cycle:
  - next cycle: ready=1, sp=0, push=0; no done pulse.
- Guard undefined: three pushes from sp=6 give sp=15 (wrap, SP_W=4), with err never asserted.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stack_ctrl_pkg
//  Description : Shared types and helpers for the stack-frame sequencer.
//                Holds the sequencer state encoding and a constant clog2
//                function that derives the field-index and occupancy
//                widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package stack_ctrl_pkg;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PUSH = 2'd1,
      ST_POP  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Ceiling log2 usable in constant expressions; clog2(1) == 0.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stack_occupancy.sv
`default_nettype none
// ============================================================================
//  Module      : stack_occupancy
//  Description : Up/down occupancy counter for the stack, SP_W bits wide.
//                Wraps modulo 2^SP_W; full/empty are decoded combinationally
//                from the count. inc_i and dec_i are mutually exclusive.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                inc_i, dec_i   - count up / count down by one word
//                sp_o           - current occupancy in words
//                full_o, empty_o- sp_o == DEPTH / sp_o == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_occupancy #(
   parameter int DEPTH = 64,
   parameter int SP_W  = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc_i,
   input  logic            dec_i,
   output logic [SP_W-1:0] sp_o,
   output logic            full_o,
   output logic            empty_o
);

   localparam logic [SP_W-1:0] c_depth = SP_W'(DEPTH);

   logic [SP_W-1:0] sp_q;
   logic [SP_W-1:0] sp_d;

   always_comb begin
      sp_d = sp_q;
      if (inc_i) begin
         sp_d = sp_q + 1'b1;
      end else if (dec_i) begin
         sp_d = sp_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   assign sp_o    = sp_q;
   assign full_o  = (sp_q == c_depth);
   assign empty_o = (sp_q == '0);

endmodule
`default_nettype wire

// File: rtl/stack_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stack_frame_ctrl
//  Description : Stack-frame sequencer. A push request stores FIELDS words
//                in ascending field order; a pop request restores them in
//                descending order. Drives push/pop strobes, push-source
//                select and one-hot destination load enables, and tracks
//                stack occupancy.
//  Build macro : STACK_FRAME_GUARD_EN - when defined, requests that would
//                overflow or underflow the stack are rejected with
//                done+err and no strobes. When undefined, err is tied 0
//                and occupancy wraps.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                push_req, pop_req   - frame requests (sampled in IDLE)
//                ready, done, err    - handshake / completion / rejection
//                push, pop           - stack strobes
//                push_src            - push-source mux select (field index)
//                en_field            - one-hot register load enable on pop
//                sp, full, empty     - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_frame_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter  int FIELDS = 3,
   parameter  int DEPTH  = 64,
   localparam int SEL_W  = (clog2(FIELDS) < 1) ? 1 : clog2(FIELDS),
   localparam int SP_W   = clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_req,
   input  logic              pop_req,
   output logic              ready,
   output logic              done,
   output logic              err,
   output logic              push,
   output logic              pop,
   output logic [SEL_W-1:0]  push_src,
   output logic [FIELDS-1:0] en_field,
   output logic [SP_W-1:0]   sp,
   output logic              full,
   output logic              empty
);

   localparam logic [SEL_W-1:0] c_idx_last = SEL_W'(FIELDS - 1);

`ifdef STACK_FRAME_GUARD_EN
   // Pop needs at least one full frame; push needs room for one.
   localparam logic [SP_W-1:0] c_fields_sp   = SP_W'(FIELDS);
   localparam logic [SP_W-1:0] c_push_max_sp = SP_W'(DEPTH - FIELDS);
`endif

   state_e           state_q;
   state_e           state_d;
   logic [SEL_W-1:0] idx_q;
   logic [SEL_W-1:0] idx_d;
   logic [SP_W-1:0]  w_sp;

`ifdef STACK_FRAME_GUARD_EN
   // Remembers that the current DONE cycle reports a rejected request.
   logic err_q;
   logic err_d;
`endif

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
`ifdef STACK_FRAME_GUARD_EN
      err_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            // Pop wins over push; a rejected pop never falls through.
            if (pop_req) begin
`ifdef STACK_FRAME_GUARD_EN
               if (w_sp < c_fields_sp) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end else
`endif
               begin
                  state_d = ST_POP;
                  idx_d   = c_idx_last;
               end
            end else if (push_req) begin
`ifdef STACK_FRAME_GUARD_EN
               if (w_sp > c_push_max_sp) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end else
`endif
               begin
                  state_d = ST_PUSH;
                  idx_d   = '0;
               end
            end
         end
         ST_PUSH: begin
            if (idx_q == c_idx_last) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_POP: begin
            if (idx_q == '0) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

`ifdef STACK_FRAME_GUARD_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Moore output decode
   // ------------------------------------------------------------------
   always_comb begin
      ready    = 1'b0;
      done     = 1'b0;
      push     = 1'b0;
      pop      = 1'b0;
      push_src = '0;
      en_field = '0;
      case (state_q)
         ST_IDLE: ready = 1'b1;
         ST_PUSH: begin
            push     = 1'b1;
            push_src = idx_q;
         end
         ST_POP: begin
            pop = 1'b1;
            for (int f = 0; f < FIELDS; f++) begin
               if (idx_q == SEL_W'(f)) begin
                  en_field[f] = 1'b1;
               end
            end
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

`ifdef STACK_FRAME_GUARD_EN
   assign err = (state_q == ST_DONE) && err_q;
`else
   assign err = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Occupancy tracking: one word per strobe cycle
   // ------------------------------------------------------------------
   stack_occupancy #(
      .DEPTH (DEPTH),
      .SP_W  (SP_W)
   ) u_occupancy (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (state_q == ST_PUSH),
      .dec_i   (state_q == ST_POP),
      .sp_o    (w_sp),
      .full_o  (full),
      .empty_o (empty)
   );

   assign sp = w_sp;

endmodule
`default_nettype wire

// File: tb/tb_stack_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_frame_ctrl
//  Description : Self-checking bench for stack_frame_ctrl (FIELDS=3,
//                DEPTH=8). A frame-level reference model predicts every
//                strobe cycle, done/err and occupancy; honours
//                STACK_FRAME_GUARD_EN the same way the design build does.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_frame_ctrl;

   localparam int FIELDS = 3;
   localparam int DEPTH  = 8;
   localparam int SEL_W  = 2;
   localparam int SP_W   = 4;
`ifdef STACK_FRAME_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              push_req;
   logic              pop_req;
   logic              ready;
   logic              done;
   logic              err;
   logic              push;
   logic              pop;
   logic [SEL_W-1:0]  push_src;
   logic [FIELDS-1:0] en_field;
   logic [SP_W-1:0]   sp;
   logic              full;
   logic              empty;

   int vectors;
   int miscompares;
   int sp_m;          // reference occupancy, modulo 2^SP_W
   bit noise;         // drive junk requests while a frame is busy

   stack_frame_ctrl #(
      .FIELDS (FIELDS),
      .DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .push_req (push_req),
      .pop_req  (pop_req),
      .ready    (ready),
      .done     (done),
      .err      (err),
      .push     (push),
      .pop      (pop),
      .push_src (push_src),
      .en_field (en_field),
      .sp       (sp),
      .full     (full),
      .empty    (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_noise();
      if (noise) begin
         push_req = 1'($urandom_range(0, 1));
         pop_req  = 1'($urandom_range(0, 1));
      end
   endtask

   // Issues one request (held for exactly one sampled edge) and checks the
   // whole frame against the model.
   task automatic run_frame(input bit pu, input bit po, input string name);
      int  wait_cnt;
      bit  do_pop;
      bit  do_push;
      bit  reject;
      logic [FIELDS-1:0] exp_en;

      wait_cnt = 0;
      while (!ready && wait_cnt < 20) begin
         tick();
         wait_cnt++;
      end
      vectors++;
      if (!ready) begin
         miscompares++;
         $display("FAIL %s ready-timeout: ready=%0b required 1", name, ready);
         return;
      end

      // Frame-level decision taken from the rules, not from DUT state.
      do_pop  = po;
      do_push = pu && !po;
      reject  = GUARD && ((do_pop && sp_m < FIELDS) ||
                          (do_push && sp_m > DEPTH - FIELDS));

      push_req = pu;
      pop_req  = po;
      tick();
      push_req = 1'b0;
      pop_req  = 1'b0;

      if (!reject) begin
         for (int i = 0; i < FIELDS; i++) begin
            int fld;
            fld    = do_pop ? (FIELDS - 1 - i) : i;
            exp_en = do_pop ? FIELDS'(1 << fld) : '0;
            vectors++;
            if (push !== do_push || pop !== do_pop || ready !== 1'b0 ||
                done !== 1'b0 || err !== 1'b0 ||
                (do_push && push_src !== SEL_W'(fld)) ||
                en_field !== exp_en || sp !== SP_W'(sp_m)) begin
               miscompares++;
               $display("FAIL %s strobe%0d: push=%0b pop=%0b src=%0d en=%b sp=%0d rdy=%0b done=%0b required push=%0b pop=%0b src=%0d en=%b sp=%0d rdy=0 done=0",
                        name, i, push, pop, push_src, en_field, sp, ready, done,
                        do_push, do_pop, fld, exp_en, sp_m);
            end
            drive_noise();
            tick();
            sp_m = do_pop ? (sp_m - 1) & 15 : (sp_m + 1) & 15;
         end
      end

      // Completion cycle (also the rejection cycle).
      vectors++;
      if (done !== 1'b1 || err !== reject || ready !== 1'b0 ||
          push !== 1'b0 || pop !== 1'b0 || en_field !== '0 ||
          sp !== SP_W'(sp_m) || full !== (sp_m == DEPTH) ||
          empty !== (sp_m == 0)) begin
         miscompares++;
         $display("FAIL %s done-cycle: done=%0b err=%0b rdy=%0b push=%0b pop=%0b sp=%0d full=%0b empty=%0b required done=1 err=%0b rdy=0 push=0 pop=0 sp=%0d full=%0b empty=%0b",
                  name, done, err, ready, push, pop, sp, full, empty,
                  reject, sp_m, (sp_m == DEPTH), (sp_m == 0));
      end
      drive_noise();
      tick();
      push_req = 1'b0;
      pop_req  = 1'b0;

      vectors++;
      if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 ||
          push !== 1'b0 || pop !== 1'b0 || sp !== SP_W'(sp_m)) begin
         miscompares++;
         $display("FAIL %s ready-return: rdy=%0b done=%0b err=%0b push=%0b pop=%0b sp=%0d required rdy=1 done=0 err=0 push=0 pop=0 sp=%0d",
                  name, ready, done, err, push, pop, sp, sp_m);
      end
   endtask

   task automatic apply_reset();
      push_req = 1'b0;
      pop_req  = 1'b0;
      rst      = 1'b1;
      tick();
      tick();
      rst  = 1'b0;
      sp_m = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++;
      if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || push !== 1'b0 ||
          pop !== 1'b0 || push_src !== '0 || en_field !== '0 || sp !== '0 ||
          empty !== 1'b1 || full !== 1'b0) begin
         miscompares++;
         $display("FAIL reset-state: rdy=%0b done=%0b err=%0b push=%0b pop=%0b src=%0d en=%b sp=%0d empty=%0b full=%0b required rdy=1 others 0 empty=1",
                  ready, done, err, push, pop, push_src, en_field, sp, empty, full);
      end
   endtask

   task automatic test_push_pop();
      apply_reset();
      run_frame(1'b1, 1'b0, "push-first");
      run_frame(1'b0, 1'b1, "pop-after-push");
   endtask

   task automatic test_priority_and_guard();
      apply_reset();
      run_frame(1'b1, 1'b0, "push-a");
      run_frame(1'b1, 1'b0, "push-b");
      run_frame(1'b1, 1'b1, "both-at-6");
      run_frame(1'b1, 1'b0, "push-c");
      run_frame(1'b1, 1'b0, "push-at-6");
      if (!GUARD) begin
         run_frame(1'b1, 1'b0, "push-wrap-1");
         run_frame(1'b1, 1'b0, "push-wrap-2");
         vectors++;
         if (sp !== 4'd15) begin
            miscompares++;
            $display("FAIL wrap-sp: sp=%0d required 15", sp);
         end
      end
      apply_reset();
      run_frame(1'b0, 1'b1, "pop-at-0");
   endtask

   task automatic test_reset_midframe();
      apply_reset();
      push_req = 1'b1;
      tick();
      push_req = 1'b0;
      tick();            // second PUSH cycle
      rst = 1'b1;
      tick();
      rst  = 1'b0;
      sp_m = 0;
      vectors++;
      if (ready !== 1'b1 || sp !== '0 || push !== 1'b0 || done !== 1'b0 ||
          err !== 1'b0 || push_src !== '0 || empty !== 1'b1) begin
         miscompares++;
         $display("FAIL midframe-reset: rdy=%0b sp=%0d push=%0b done=%0b err=%0b src=%0d empty=%0b required rdy=1 sp=0 push=0 done=0 err=0 src=0 empty=1",
                  ready, sp, push, done, err, push_src, empty);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || ready !== 1'b1 || sp !== '0) begin
         miscompares++;
         $display("FAIL midframe-nodone: done=%0b rdy=%0b sp=%0d required done=0 rdy=1 sp=0",
                  done, ready, sp);
      end
   endtask

   task automatic test_random();
      apply_reset();
      noise = 1'b1;
      for (int n = 0; n < 60; n++) begin
         int kind;
         int gap;
         kind = $urandom_range(0, 2);
         gap  = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) tick();
         case (kind)
            0:       run_frame(1'b1, 1'b0, "rand-push");
            1:       run_frame(1'b0, 1'b1, "rand-pop");
            default: run_frame(1'b1, 1'b1, "rand-both");
         endcase
      end
      noise = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      sp_m        = 0;
      noise       = 1'b0;
      rst         = 1'b1;
      push_req    = 1'b0;
      pop_req     = 1'b0;

      test_reset();
      test_push_pop();
      test_priority_and_guard();
      test_reset_midframe();
      test_random();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
